// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory responder: FSM states,
// default geometry and the per-byte even-parity helper.
package mem_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;
    localparam int DEF_DATA_W = 32;
    localparam int LANES      = 4;
    localparam int LANE_W     = DEF_DATA_W / LANES;

    // Even parity per byte lane: the stored bit makes the lane's ones-count even.
    function automatic logic [LANES-1:0] lane_parity(input logic [LANES*LANE_W-1:0] word);
        logic [LANES-1:0] p;
        for (int i = 0; i < LANES; i++) begin
            p[i] = ^word[i*LANE_W +: LANE_W];
        end
        return p;
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational write merge: replaces the enabled byte lanes of the old word
// with write data. Carries per-lane parity alongside when MEM_PARITY_EN is defined.
module byte_lane_merge
    import mem_pkg::*;
(
    input  logic [LANES*LANE_W-1:0] old_word,
    input  logic [LANES*LANE_W-1:0] wdata,
    input  logic [LANES-1:0]        byte_en,
`ifdef MEM_PARITY_EN
    input  logic [LANES-1:0]        old_par,
    output logic [LANES-1:0]        new_par,
`endif
    output logic [LANES*LANE_W-1:0] new_word
);

`ifdef MEM_PARITY_EN
    logic [LANES-1:0] wdata_par;
    assign wdata_par = lane_parity(wdata);
`endif

    always_comb begin
        new_word = old_word;
`ifdef MEM_PARITY_EN
        new_par  = old_par;
`endif
        for (int i = 0; i < LANES; i++) begin
            if (byte_en[i]) begin
                new_word[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
`ifdef MEM_PARITY_EN
                new_par[i] = wdata_par[i];
`endif
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// 64x32 data store with valid/ready request and response channels, byte-lane
// writes and a post-reset clear sweep. Optional per-byte parity: MEM_PARITY_EN.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Mem_Write,
    input  logic [ADDR_W-1:0] Mem_Addr,
    input  logic [3:0]        Byte_En,
    input  logic [DATA_W-1:0] M_W_Data,
    output logic              Rsp_Valid,
    input  logic              Rsp_Ready,
    output logic [DATA_W-1:0] M_R_Data,
    output logic              Init_Busy,
    output logic              Parity_Err,
    output logic [1:0]        state_dbg
);

    // Handshakes: a request transfers at a rising edge where Req_Valid && Req_Ready;
    // a response transfers where Rsp_Valid && Rsp_Ready. Valid holds its payload
    // stable until the transfer happens.

    state_e            state;
    logic [ADDR_W-1:0] init_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged_word;
    logic [DATA_W-1:0] rsp_word;
    logic              accept;

    assign state_dbg = state;
    assign Req_Ready = (state == IDLE) || ((state == RESP) && Rsp_Ready);
    assign accept    = Req_Valid && Req_Ready;
    assign old_word  = mem[Mem_Addr];
    assign rsp_word  = Mem_Write ? merged_word : old_word;

`ifdef MEM_PARITY_EN
    logic [LANES-1:0] par_mem [DEPTH];
    logic [LANES-1:0] old_par;
    logic [LANES-1:0] merged_par;
    logic [LANES-1:0] rsp_par;

    assign old_par = par_mem[Mem_Addr];
    assign rsp_par = Mem_Write ? merged_par : old_par;

    byte_lane_merge u_merge (
        .old_word (old_word),
        .wdata    (M_W_Data),
        .byte_en  (Byte_En),
        .old_par  (old_par),
        .new_par  (merged_par),
        .new_word (merged_word)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            if (state == INIT) begin
                par_mem[init_cnt] <= '0;
            end else if (accept && Mem_Write) begin
                par_mem[Mem_Addr] <= merged_par;
            end
        end
    end

    // Parity is checked against the data actually returned, so a corrupted
    // stored bit is reported with its response.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Parity_Err <= 1'b0;
        end else if (accept) begin
            Parity_Err <= |(lane_parity(rsp_word) ^ rsp_par);
        end
    end
`else
    byte_lane_merge u_merge (
        .old_word (old_word),
        .wdata    (M_W_Data),
        .byte_en  (Byte_En),
        .new_word (merged_word)
    );

    assign Parity_Err = 1'b0;
`endif

    // The array has no reset; the INIT sweep zeroes it instead.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            if (state == INIT) begin
                mem[init_cnt] <= '0;
            end else if (accept && Mem_Write) begin
                mem[Mem_Addr] <= merged_word;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= INIT;
            init_cnt  <= '0;
            Rsp_Valid <= 1'b0;
            M_R_Data  <= '0;
            Init_Busy <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                        state     <= IDLE;
                        Init_Busy <= 1'b0;
                    end
                end
                IDLE, RESP: begin
                    if (accept) begin
                        M_R_Data  <= rsp_word;
                        Rsp_Valid <= 1'b1;
                        state     <= RESP;
                    end else if ((state == RESP) && Rsp_Ready) begin
                        Rsp_Valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: scoreboard queue filled by the driver,
// drained by a response monitor. Parity corruption case needs MEM_PARITY_EN.
module tb_data_mem_responder;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Req_Valid = 1'b0;
    logic        Req_Ready;
    logic        Mem_Write = 1'b0;
    logic [5:0]  Mem_Addr = '0;
    logic [3:0]  Byte_En = '0;
    logic [31:0] M_W_Data = '0;
    logic        Rsp_Valid;
    logic        Rsp_Ready = 1'b1;
    logic [31:0] M_R_Data;
    logic        Init_Busy;
    logic        Parity_Err;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    // Expected response: {parity_err, data}
    logic [32:0] exp_q[$];

    data_mem_responder dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Req_Valid  (Req_Valid),
        .Req_Ready  (Req_Ready),
        .Mem_Write  (Mem_Write),
        .Mem_Addr   (Mem_Addr),
        .Byte_En    (Byte_En),
        .M_W_Data   (M_W_Data),
        .Rsp_Valid  (Rsp_Valid),
        .Rsp_Ready  (Rsp_Ready),
        .M_R_Data   (M_R_Data),
        .Init_Busy  (Init_Busy),
        .Parity_Err (Parity_Err),
        .state_dbg  (state_dbg)
    );

    // Clock
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%09h expected 0x%09h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected response per completed response transfer.
    always @(negedge Clk) begin
        if (!Rst && Rsp_Valid && Rsp_Ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got 0x%08h with no expected response", M_R_Data);
            end else begin
                check("rsp_data", {Parity_Err, M_R_Data}, exp_q.pop_front());
            end
        end
    end

    // Driver tasks: all start and end at posedge+1.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send(input logic wr, input logic [5:0] addr, input logic [3:0] be,
                        input logic [31:0] data, input logic [32:0] exp);
        int n;
        Req_Valid = 1'b1;
        Mem_Write = wr;
        Mem_Addr  = addr;
        Byte_En   = be;
        M_W_Data  = data;
        exp_q.push_back(exp);
        n = 0;
        @(negedge Clk);
        while (!Req_Ready && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (!Req_Ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: Req_Ready got 0 expected 1 within 200 cycles");
            void'(exp_q.pop_back());
            @(posedge Clk);
            #1;
            Req_Valid = 1'b0;
            return;
        end
        @(posedge Clk);
        #1;
        Req_Valid = 1'b0;
        check("rsp_latency", {32'b0, Rsp_Valid}, 33'd1);
    endtask

    // Applies one reset edge, checks reset values, then times the clear sweep.
    task automatic reset_and_sweep();
        Rst = 1'b1;
        exp_q.delete();
        @(posedge Clk);
        #1;
        check("rst_rsp_valid", {32'b0, Rsp_Valid}, 33'd0);
        check("rst_rdata", {1'b0, M_R_Data}, 33'd0);
        check("rst_init_busy", {32'b0, Init_Busy}, 33'd1);
        check("rst_req_ready", {32'b0, Req_Ready}, 33'd0);
        check("rst_parity_err", {32'b0, Parity_Err}, 33'd0);
        check("rst_state", {31'b0, state_dbg}, 33'd0);
        Rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge Clk);
            check("sweep_busy", {31'b0, Init_Busy, Req_Ready}, 33'b10);
        end
        @(negedge Clk);
        check("sweep_done", {31'b0, Init_Busy, Req_Ready}, 33'b01);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int n;
        // Power-on reset held for a couple of cycles.
        idle(2);
        reset_and_sweep();

        // Swept memory reads zero at the top address.
        send(1'b0, 6'h3F, 4'h0, 32'h0, {1'b0, 32'h0000_0000});

        // Full-word write then read back.
        send(1'b1, 6'd1, 4'hF, 32'h0000_000F, {1'b0, 32'h0000_000F});
        send(1'b0, 6'd1, 4'h0, 32'h0, {1'b0, 32'h0000_000F});

        // Byte-lane merge and empty byte enable.
        send(1'b1, 6'd2, 4'hF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFF});
        send(1'b1, 6'd2, 4'b0101, 32'h003C_C381, {1'b0, 32'hFF3C_FF81});
        send(1'b0, 6'd2, 4'h0, 32'h0, {1'b0, 32'hFF3C_FF81});
        send(1'b1, 6'd2, 4'h0, 32'h1234_5678, {1'b0, 32'hFF3C_FF81});
        send(1'b0, 6'd2, 4'h0, 32'h0, {1'b0, 32'hFF3C_FF81});

        // Back-to-back stream including read-after-write on the same address.
        idle(2);
        send(1'b1, 6'd5, 4'hF, 32'h0000_0DB0, {1'b0, 32'h0000_0DB0});
        send(1'b0, 6'd5, 4'h0, 32'h0, {1'b0, 32'h0000_0DB0});
        send(1'b0, 6'd6, 4'h0, 32'h0, {1'b0, 32'h0000_0000});
        idle(2);

        // Backpressure: response holds and no new request is accepted.
        Rsp_Ready = 1'b0;
        send(1'b0, 6'd5, 4'h0, 32'h0, {1'b0, 32'h0000_0DB0});
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("hold_valid", {32'b0, Rsp_Valid}, 33'd1);
            check("hold_rdata", {1'b0, M_R_Data}, {1'b0, 32'h0000_0DB0});
            check("hold_req_ready", {32'b0, Req_Ready}, 33'd0);
        end
        @(posedge Clk);
        #1;

        // Reset during the hold drops the pending response and re-sweeps.
        reset_and_sweep();
        Rsp_Ready = 1'b1;
        send(1'b0, 6'd5, 4'h0, 32'h0, {1'b0, 32'h0000_0000});
        send(1'b0, 6'd2, 4'h0, 32'h0, {1'b0, 32'h0000_0000});

`ifdef MEM_PARITY_EN
        // Corrupt one stored data bit; only that word reports a parity error.
        send(1'b1, 6'd7, 4'hF, 32'hA5A5_A5A5, {1'b0, 32'hA5A5_A5A5});
        idle(2);
        dut.mem[7] = dut.mem[7] ^ 32'h0000_0008;
        send(1'b0, 6'd7, 4'h0, 32'h0, {1'b1, 32'hA5A5_A5AD});
        send(1'b0, 6'd1, 4'h0, 32'h0, {1'b0, 32'h0000_0000});
`else
        send(1'b0, 6'd7, 4'h0, 32'h0, {1'b0, 32'h0000_0000});
`endif

        // Drain outstanding responses with a bound.
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            idle(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        idle(2);
        check("final_idle_valid", {32'b0, Rsp_Valid}, 33'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
